// File: rtl/regfile_pkg.sv
// Shared register-file parameters and the writeback priority-state type.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  // Names the requester that wins the next tie.
  typedef enum logic {
    PRI_ALU = 1'b0,
    PRI_MEM = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback requests, issue/hazard-check signals and write-port outputs.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic             alu_valid;
  logic             alu_ready;
  reg_addr_t        alu_addr;
  reg_data_t        alu_data;

  logic             mem_valid;
  logic             mem_ready;
  reg_addr_t        mem_addr;
  reg_data_t        mem_data;

  logic             iss_valid;
  reg_addr_t        iss_addr;

  reg_addr_t        chk_addr1;
  reg_addr_t        chk_addr2;
  logic             hazard1;
  logic             hazard2;

  logic             reg_write;
  reg_addr_t        write_addr;
  reg_data_t        write_data;

  logic [NUM_REGS-1:0] busy;
  logic [15:0]      conflict_cnt;

  // Pipeline side: drives requests, issue and check addresses.
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output iss_valid, iss_addr, chk_addr1, chk_addr2,
    input  alu_ready, mem_ready, hazard1, hazard2,
    input  reg_write, write_addr, write_data, busy, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  iss_valid, iss_addr, chk_addr1, chk_addr2,
    output alu_ready, mem_ready, hazard1, hazard2,
    output reg_write, write_addr, write_data, busy, conflict_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input arbiter (ALU vs MEM) with round-robin or fixed MEM priority.
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_o,
  output logic gnt_mem_o
);

  pri_e state_q;
  pri_e state_d;

  // Grant and next priority; grants are suppressed while in reset.
  always_comb begin
    gnt_alu_o = 1'b0;
    gnt_mem_o = 1'b0;
    state_d   = state_q;
    if (reset_n) begin
      if (req_alu_i && !req_mem_i) begin
        gnt_alu_o = 1'b1;
      end else if (!req_alu_i && req_mem_i) begin
        gnt_mem_o = 1'b1;
      end else if (req_alu_i && req_mem_i) begin
        if (FIXED_PRIO || state_q == PRI_MEM) begin
          gnt_mem_o = 1'b1;
        end else begin
          gnt_alu_o = 1'b1;
        end
      end
      // Fixed priority never leaves PRI_ALU.
      if (!FIXED_PRIO) begin
        if (gnt_alu_o) begin
          state_d = PRI_MEM;
        end else if (gnt_mem_o) begin
          state_d = PRI_ALU;
        end
      end
    end
  end

  // Priority state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= PRI_ALU;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: picks ALU or MEM result, registers the write port,
// tracks pending destinations and counts contention cycles.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic          alu_gnt;
  logic          mem_gnt;
  logic          xfer;
  reg_addr_t     xfer_addr;
  reg_data_t     xfer_data;

  logic          reg_write_q,  reg_write_d;
  reg_addr_t     write_addr_q, write_addr_d;
  reg_data_t     write_data_q, write_data_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [15:0]   cnt_q, cnt_d;

  rr_arbiter2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_alu_i (bus.alu_valid),
    .req_mem_i (bus.mem_valid),
    .gnt_alu_o (alu_gnt),
    .gnt_mem_o (mem_gnt)
  );

  assign xfer      = alu_gnt | mem_gnt;
  assign xfer_addr = mem_gnt ? bus.mem_addr : bus.alu_addr;
  assign xfer_data = mem_gnt ? bus.mem_data : bus.alu_data;

  assign bus.alu_ready    = alu_gnt;
  assign bus.mem_ready    = mem_gnt;
  assign bus.hazard1      = reset_n & busy_q[bus.chk_addr1];
  assign bus.hazard2      = reset_n & busy_q[bus.chk_addr2];
  assign bus.reg_write    = reg_write_q;
  assign bus.write_addr   = write_addr_q;
  assign bus.write_data   = write_data_q;
  assign bus.busy         = busy_q;
  assign bus.conflict_cnt = cnt_q;

  // Next write port, scoreboard and contention counter.
  always_comb begin
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    busy_d       = busy_q;
    cnt_d        = cnt_q;
    if (xfer) begin
      write_addr_d = xfer_addr;
      write_data_d = xfer_data;
      reg_write_d  = (xfer_addr != '0);
      if (xfer_addr != '0) begin
        busy_d[xfer_addr] = 1'b0;
      end
    end
    // Issue is applied after the clear: a same-cycle issue is the younger event.
    if (bus.iss_valid && bus.iss_addr != '0) begin
      busy_d[bus.iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (bus.alu_valid && bus.mem_valid && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      busy_q       <= '0;
      cnt_q        <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// against a behavioural model; a second instance covers fixed MEM priority.
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset_n;

  regfile_wb_arbiter_if if0 ();
  regfile_wb_arbiter_if if1 ();

  regfile_wb_arbiter #(.FIXED_PRIO(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  regfile_wb_arbiter #(.FIXED_PRIO(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of dut0 (round robin).
  logic [31:0] m_busy    = '0;
  logic        m_tie_mem = 1'b0;   // 1: MEM wins the next tie
  int          m_cnt     = 0;
  logic        m_wr      = 1'b0;
  logic [4:0]  m_waddr   = '0;
  logic [31:0] m_wdata   = '0;
  logic        alu_hold  = 1'b0;
  logic        mem_hold  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_all();
    if0.alu_valid = 0; if0.alu_addr = 0; if0.alu_data = 0;
    if0.mem_valid = 0; if0.mem_addr = 0; if0.mem_data = 0;
    if0.iss_valid = 0; if0.iss_addr = 0; if0.chk_addr1 = 0; if0.chk_addr2 = 0;
    if1.alu_valid = 0; if1.alu_addr = 0; if1.alu_data = 0;
    if1.mem_valid = 0; if1.mem_addr = 0; if1.mem_data = 0;
    if1.iss_valid = 0; if1.iss_addr = 0; if1.chk_addr1 = 0; if1.chk_addr2 = 0;
  endtask

  // One clock of dut0: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    logic ea, em, both;
    logic [4:0]  wa;
    logic [31:0] wd;
    #1;
    both = if0.alu_valid && if0.mem_valid;
    ea = reset_n && if0.alu_valid && (!if0.mem_valid || !m_tie_mem);
    em = reset_n && if0.mem_valid && (!if0.alu_valid || m_tie_mem);
    check_eq("alu_ready", if0.alu_ready, ea);
    check_eq("mem_ready", if0.mem_ready, em);
    check_eq("hazard1", if0.hazard1, reset_n && m_busy[if0.chk_addr1]);
    check_eq("hazard2", if0.hazard2, reset_n && m_busy[if0.chk_addr2]);
    @(posedge clk);
    if (!reset_n) begin
      m_busy = '0; m_tie_mem = 1'b0; m_cnt = 0;
      m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (ea || em) begin
        wa = em ? if0.mem_addr : if0.alu_addr;
        wd = em ? if0.mem_data : if0.alu_data;
        m_wr = (wa != 0);
        m_waddr = wa;
        m_wdata = wd;
        if (wa != 0) m_busy[wa] = 1'b0;
        m_tie_mem = ea;
      end else begin
        m_wr = 1'b0;
      end
      if (if0.iss_valid && if0.iss_addr != 0) m_busy[if0.iss_addr] = 1'b1;
      if (both && m_cnt < 65535) m_cnt++;
    end
    alu_hold = if0.alu_valid && !ea;
    mem_hold = if0.mem_valid && !em;
    @(negedge clk);
    check_eq("reg_write", if0.reg_write, m_wr);
    check_eq("write_addr", if0.write_addr, m_waddr);
    check_eq("write_data", if0.write_data, m_wdata);
    check_eq("busy", if0.busy, m_busy);
    check_eq("conflict_cnt", if0.conflict_cnt, m_cnt);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    cycle();
    cycle();
    reset_n = 1'b1;

    // Single ALU request.
    if0.alu_valid = 1; if0.alu_addr = 5; if0.alu_data = 32'hDEADBEEF;
    cycle();
    check_eq("single_wr", if0.reg_write, 1);
    check_eq("single_addr", if0.write_addr, 5);
    check_eq("single_data", if0.write_data, 32'hDEADBEEF);
    idle_all();
    cycle();
    check_eq("idle_wr", if0.reg_write, 0);

    // Contention from a fresh reset, both instances.
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    if0.alu_valid = 1; if0.alu_addr = 3; if0.alu_data = 32'h33;
    if0.mem_valid = 1; if0.mem_addr = 4; if0.mem_data = 32'h44;
    if1.alu_valid = 1; if1.alu_addr = 3; if1.alu_data = 32'h33;
    if1.mem_valid = 1; if1.mem_addr = 4; if1.mem_data = 32'h44;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("rr_order", if0.write_addr, (i % 2 == 0) ? 3 : 4);
      check_eq("fixed_alu_rdy", if1.alu_ready, 0);
      check_eq("fixed_mem_rdy", if1.mem_ready, 1);
      check_eq("fixed_addr", if1.write_addr, 4);
    end
    idle_all();
    cycle();
    check_eq("rr_cnt4", if0.conflict_cnt, 4);
    check_eq("fixed_cnt4", if1.conflict_cnt, 4);

    // Scoreboard on register 7.
    if0.iss_valid = 1; if0.iss_addr = 7; if0.chk_addr1 = 7;
    cycle();
    if0.iss_valid = 0;
    cycle();
    check_eq("hz7_set", if0.hazard1, 1);
    if0.mem_valid = 1; if0.mem_addr = 7; if0.mem_data = 32'h77;
    if0.iss_valid = 1; if0.iss_addr = 7;
    cycle();
    check_eq("hz7_sim", if0.hazard1, 1);
    if0.iss_valid = 0;
    cycle();
    check_eq("hz7_clr", if0.hazard1, 0);
    idle_all();
    cycle();

    // Zero register.
    if0.iss_valid = 1; if0.iss_addr = 0;
    if0.alu_valid = 1; if0.alu_addr = 0; if0.alu_data = 32'h1234;
    if0.chk_addr2 = 0;
    cycle();
    check_eq("zero_wr", if0.reg_write, 0);
    check_eq("zero_busy", if0.busy, 0);
    check_eq("zero_hz2", if0.hazard2, 0);
    idle_all();
    cycle();

    // Reset mid-operation.
    if0.iss_valid = 1; if0.iss_addr = 9;
    cycle();
    if0.iss_valid = 0;
    if0.alu_valid = 1; if0.alu_addr = 12; if0.alu_data = 32'hCAFE;
    if0.mem_valid = 1; if0.mem_addr = 13; if0.mem_data = 32'hF00D;
    cycle();
    reset_n = 1'b0;
    cycle();
    check_eq("rst_wr", if0.reg_write, 0);
    check_eq("rst_busy", if0.busy, 0);
    check_eq("rst_cnt", if0.conflict_cnt, 0);
    reset_n = 1'b1;
    cycle();
    check_eq("rst_rr_alu", if0.write_addr, 12);
    idle_all();
    cycle();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      reset_n = ($urandom_range(0, 49) != 0);
      if (!alu_hold) begin
        if0.alu_valid = $urandom_range(0, 1);
        if0.alu_addr  = 5'($urandom_range(0, 31));
        if0.alu_data  = $urandom;
      end
      if (!mem_hold) begin
        if0.mem_valid = $urandom_range(0, 1);
        if0.mem_addr  = 5'($urandom_range(0, 31));
        if0.mem_data  = $urandom;
      end
      if0.iss_valid = $urandom_range(0, 1);
      if0.iss_addr  = 5'($urandom_range(0, 31));
      if0.chk_addr1 = 5'($urandom_range(0, 31));
      if0.chk_addr2 = 5'($urandom_range(0, 31));
      cycle();
    end

    // Counter saturation on both instances.
    idle_all();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    if0.alu_valid = 1; if0.mem_valid = 1;
    if1.alu_valid = 1; if1.mem_valid = 1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check_eq("sat_fffe", if0.conflict_cnt, 16'hFFFE);
    check_eq("sat_fffe_fx", if1.conflict_cnt, 16'hFFFE);
    @(posedge clk);
    @(negedge clk);
    check_eq("sat_ffff", if0.conflict_cnt, 16'hFFFF);
    repeat (4465) @(posedge clk);
    @(negedge clk);
    check_eq("sat_hold", if0.conflict_cnt, 16'hFFFF);
    check_eq("sat_hold_fx", if1.conflict_cnt, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
